// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter and bus slaves:
// FSM state encodings, arbitration mode codes, bus widths.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 8;

    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbiter handshake bundle: req/grant per master, bus_req/bus_ready
// slave framing, status busy/owner/timeout. slave = arbiter side.
interface bus_arbiter_if
    import bus_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 8
) ();
    localparam int OW = owner_w(N_MASTERS);

    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] grant;
    logic                 bus_req;
    logic                 bus_ready;
    logic                 busy;
    logic [OW-1:0]        owner;
    logic                 timeout;

    modport master (
        output req, bus_ready,
        input  grant, bus_req, busy, owner, timeout
    );

    modport slave (
        input  req, bus_ready,
        output grant, bus_req, busy, owner, timeout
    );
endinterface

// File: rtl/bus_arbiter_picker.sv
// Combinational winner select: req, ptr -> winner, valid.
// Round robin searches indices >= ptr first, then wraps to all.
module bus_arbiter_picker
    import bus_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 8,
    parameter int MODE      = ARB_RR,
    parameter int OW        = owner_w(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [OW-1:0]        ptr,
    output logic [OW-1:0]        winner,
    output logic                 valid
);
    logic [N_MASTERS-1:0] masked;
    logic [N_MASTERS-1:0] pool;

    always_comb begin
        masked = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (MODE == ARB_RR && i >= int'(ptr)) begin
                masked[i] = req[i];
            end
        end
        pool = (|masked) ? masked : req;
        winner = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (pool[i]) begin
                winner = OW'(i);
            end
        end
        valid = |req;
    end
endmodule

// File: rtl/bus_arbiter.sv
// N-master bus arbiter: IDLE->GRANT->ACCESS->RELEASE, registered outputs.
// Ports: clk, clr (sync high), bus (slave modport). Macro: BUS_ARB_TIMEOUT_EN.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int N_MASTERS      = 8,
    parameter int MODE           = ARB_RR,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           clk,
    input  logic           clr,
    bus_arbiter_if.slave   bus
);
    localparam int OW = owner_w(N_MASTERS);

    if (N_MASTERS < 2 || N_MASTERS > 16 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad
        $error("bus_arbiter: parameter out of range");
    end

    state_t               state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic                 bus_req_q, bus_req_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [OW-1:0]        ptr_q, ptr_d;
    logic                 timeout_q, timeout_d;
    logic [OW-1:0]        pick;
    logic                 pick_valid;
`ifdef BUS_ARB_TIMEOUT_EN
    logic [15:0]          cnt_q, cnt_d;
`endif

    bus_arbiter_picker #(
        .N_MASTERS (N_MASTERS),
        .MODE      (MODE),
        .OW        (OW)
    ) u_picker (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (pick),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            bus_req_q <= 1'b0;
            owner_q   <= '0;
            ptr_q     <= '0;
            timeout_q <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            bus_req_q <= bus_req_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        bus_req_d = bus_req_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                grant_d   = '0;
                bus_req_d = 1'b0;
                if (pick_valid) begin
                    grant_d[pick] = 1'b1;
                    owner_d       = pick;
                    state_d       = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Owner gave up before the access: drop without touching ptr.
                if (bus.req[owner_q]) begin
                    bus_req_d = 1'b1;
                    state_d   = ST_ACCESS;
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end else begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (bus.bus_ready) begin
                    grant_d   = '0;
                    bus_req_d = 1'b0;
                    state_d   = ST_RELEASE;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    grant_d   = '0;
                    bus_req_d = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            ST_RELEASE: begin
                ptr_d   = (owner_q == OW'(N_MASTERS - 1)) ? '0
                                                          : owner_q + OW'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.grant   = grant_q;
    assign bus.bus_req = bus_req_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = (state_q != ST_IDLE);
`ifdef BUS_ARB_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    a_grant_onehot: assert property (
        @(posedge clk) disable iff (clr) $onehot0(grant_q)
    );
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench: fixed-priority and round-robin arbiters driven
// in lockstep, checked against a transaction-level reference model.
module tb_bus_arbiter;
    localparam int N  = 8;
    localparam int TO = 10;

    logic clk;
    logic clr;
    int   n_chk;
    int   n_pass;
    int   ptr_f, ptr_r;
    int   own_f, own_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_if #(.N_MASTERS(N)) bif_f ();
    bus_arbiter_if #(.N_MASTERS(N)) bif_r ();

    bus_arbiter #(
        .N_MASTERS(N), .MODE(0), .TIMEOUT_CYCLES(TO)
    ) u_fix (
        .clk (clk), .clr (clr), .bus (bif_f)
    );

    bus_arbiter #(
        .N_MASTERS(N), .MODE(1), .TIMEOUT_CYCLES(TO)
    ) u_rr (
        .clk (clk), .clr (clr), .bus (bif_r)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [7:0] r, logic rdy);
        bif_f.req       = r;
        bif_r.req       = r;
        bif_f.bus_ready = rdy;
        bif_r.bus_ready = rdy;
    endtask

    task automatic set_rdy(logic rdy);
        bif_f.bus_ready = rdy;
        bif_r.bus_ready = rdy;
    endtask

    // Fixed priority: lowest set bit. Round robin: lowest >= ptr, else lowest.
    function automatic int pick(logic [7:0] r, int mode, int ptr);
        if (mode == 1)
            for (int i = ptr; i < N; i++) if (r[i]) return i;
        for (int i = 0; i < N; i++) if (r[i]) return i;
        return -1;
    endfunction

    task automatic expect_out(string tag, int gf, int gr,
                              bit breq, bit bsy, bit to);
        chk({tag, ".grant_f"}, 32'(bif_f.grant), gf);
        chk({tag, ".grant_r"}, 32'(bif_r.grant), gr);
        chk({tag, ".owner_f"}, 32'(bif_f.owner), own_f);
        chk({tag, ".owner_r"}, 32'(bif_r.owner), own_r);
        chk({tag, ".breq"}, {bif_f.bus_req, bif_r.bus_req}, {breq, breq});
        chk({tag, ".busy"}, {bif_f.busy, bif_r.busy}, {bsy, bsy});
        chk({tag, ".tmo"}, {bif_f.timeout, bif_r.timeout}, {to, to});
    endtask

    task automatic txn(logic [7:0] r, int dly, bit abort,
                       bit drop, bit noise);
        int wf, wr;
        wf = pick(r, 0, ptr_f);
        wr = pick(r, 1, ptr_r);
        drive(r, noise);
        tick();
        own_f = wf;
        own_r = wr;
        expect_out("grant", 1 << wf, 1 << wr, 0, 1, 0);
        if (abort) begin
            drive(8'h00, noise);
            tick();
            expect_out("abort", 0, 0, 0, 0, 0);
            set_rdy(1'b0);
            return;
        end
        set_rdy(noise);
        tick();
        set_rdy(1'b0);
        if (drop) drive(8'h00, 1'b0);
        expect_out("access", 1 << wf, 1 << wr, 1, 1, 0);
        for (int i = 0; i < dly; i++) begin
            tick();
            expect_out("wait", 1 << wf, 1 << wr, 1, 1, 0);
        end
        set_rdy(1'b1);
        tick();
        expect_out("release", 0, 0, 0, 1, 0);
        ptr_f = (wf + 1) % N;
        ptr_r = (wr + 1) % N;
        set_rdy(noise);
        tick();
        expect_out("idle", 0, 0, 0, 0, 0);
        drive(8'h00, 1'b0);
    endtask

    task automatic timeout_test(logic [7:0] r);
        int wf, wr;
        wf = pick(r, 0, ptr_f);
        wr = pick(r, 1, ptr_r);
        drive(r, 1'b0);
        tick();
        own_f = wf;
        own_r = wr;
        tick();
        expect_out("to_access", 1 << wf, 1 << wr, 1, 1, 0);
`ifdef BUS_ARB_TIMEOUT_EN
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            expect_out("to_wait", 1 << wf, 1 << wr, 1, 1, 0);
        end
        tick();
        expect_out("to_fire", 0, 0, 0, 1, 1);
        tick();
        expect_out("to_idle", 0, 0, 0, 0, 0);
`else
        for (int i = 0; i < 2 * TO; i++) begin
            tick();
            expect_out("no_to_wait", 1 << wf, 1 << wr, 1, 1, 0);
        end
        set_rdy(1'b1);
        tick();
        expect_out("no_to_rel", 0, 0, 0, 1, 0);
        set_rdy(1'b0);
        tick();
        expect_out("no_to_idle", 0, 0, 0, 0, 0);
`endif
        ptr_f = (wf + 1) % N;
        ptr_r = (wr + 1) % N;
        drive(8'h00, 1'b0);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        ptr_f = 0;
        ptr_r = 0;
        own_f = 0;
        own_r = 0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        drive(8'h00, 1'b0);
        clr = 1'b1;
        tick();
        do_reset();
        expect_out("reset", 0, 0, 0, 0, 0);

        for (int k = 0; k < 3; k++) txn(8'b0000_0110, 3, 0, 0, 0);
        txn(8'h08, 0, 1, 0, 0);
        txn(8'h10, 2, 0, 0, 1);
        txn(8'h81, 9, 0, 1, 0);
        timeout_test(8'h44);

        drive(8'h20, 1'b0);
        tick();
        tick();
        chk("pre_clr.owner_r", 32'(bif_r.owner), 5);
        chk("pre_clr.breq", 32'(bif_r.bus_req), 1);
        do_reset();
        expect_out("mid_clr", 0, 0, 0, 0, 0);
        drive(8'h00, 1'b0);
        tick();
        expect_out("post_clr", 0, 0, 0, 0, 0);

        drive(8'hFF, 1'b1);
        for (int t = 1; t <= 32; t++) begin
            int ph;
            int g;
            tick();
            ph = t % 4;
            own_r = ((t - 1) / 4) % N;
            own_f = 0;
            g = (ph == 1 || ph == 2);
            expect_out("b2b", g, g << own_r, ph == 2, ph != 0, 0);
        end
        drive(8'h00, 1'b0);
        ptr_f = 1;
        ptr_r = 0;

        for (int k = 0; k < 40; k++) begin
            int gap;
            txn(8'($urandom_range(1, 255)), $urandom_range(0, 4),
                ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
                $urandom_range(0, 1));
            gap = $urandom_range(0, 2);
            for (int i = 0; i < gap; i++) begin
                tick();
                expect_out("gap", 0, 0, 0, 0, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
